// File: rtl/net_pkg.sv
// Shared network-TX definitions: protocol numbers, UDP header geometry, FSM
// state type and the one's-complement checksum helpers.
package net_pkg;

    localparam logic [7:0]  PROTO_UDP     = 8'd17;
    localparam logic [7:0]  PROTO_TCP     = 8'd6;
    localparam int unsigned UDP_HDR_BYTES = 8;
    localparam int unsigned UDP_HDR_BITS  = UDP_HDR_BYTES * 8;
    localparam int unsigned SUM_WORDS     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_FOLD = 2'd2,
        ST_SEND = 2'd3
    } tx_state_e;

    function automatic logic [19:0] oc_add(input logic [19:0] acc, input logic [15:0] word);
        return acc + {4'h0, word};
    endfunction

    // Two carry folds are always enough for a 20-bit accumulator of 16-bit words.
    function automatic logic [15:0] oc_fold(input logic [19:0] acc);
        logic [19:0] s1;
        logic [19:0] s2;
        s1 = {4'h0, acc[15:0]} + {16'h0, acc[19:16]};
        s2 = {4'h0, s1[15:0]}  + {16'h0, s1[19:16]};
        return s2[15:0];
    endfunction

endpackage

// File: rtl/transport_hdr_tx_if.sv
// Start/field bus and header beat stream of transport_hdr_tx, grouped as one interface.
interface transport_hdr_tx_if #(
    parameter int N = 2
);
    logic        axiiv;
    logic [7:0]  protocol_in;
    logic [31:0] src_ip_in;
    logic [31:0] dst_ip_in;
    logic [15:0] data_length_in;
    logic [15:0] data_checksum_in;
    logic [15:0] udp_src_port_in;
    logic [15:0] udp_dst_port_in;
    logic        axiir;
    logic        axiov;
    logic [N-1:0] axiod;
    logic        axi_last;

    modport master (
        output axiiv, protocol_in, src_ip_in, dst_ip_in, data_length_in,
               data_checksum_in, udp_src_port_in, udp_dst_port_in, axiir,
        input  axiov, axiod, axi_last
    );

    modport slave (
        input  axiiv, protocol_in, src_ip_in, dst_ip_in, data_length_in,
               data_checksum_in, udp_src_port_in, udp_dst_port_in, axiir,
        output axiov, axiod, axi_last
    );
endinterface

// File: rtl/ones_comp_acc.sv
// 16-bit word one's-complement accumulator with clear/add controls and a
// combinational folded-and-complemented checksum output.
module ones_comp_acc
    import net_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] word,
    output logic [15:0] csum
);

    logic [19:0] acc_q;
    logic [19:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = oc_add(acc_q, word);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign csum = ~oc_fold(acc_q);

endmodule

// File: rtl/transport_hdr_tx.sv
// UDP header generator: latches pseudo-header and port fields on start, sums the
// checksum over ten cycles, then streams the 8-byte header MSB-first in N-bit beats.
module transport_hdr_tx
    import net_pkg::*;
#(
    parameter int N           = 2,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    transport_hdr_tx_if.slave  bus,
    output logic               busy,
    output logic               err
);

    localparam int unsigned BEATS     = UDP_HDR_BITS / N;
    localparam logic [6:0]  LAST_BEAT = 7'(BEATS - 1);

    tx_state_e   state_q, state_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [15:0] len_q, len_d;
    logic [15:0] dcs_q, dcs_d;
    logic [15:0] sport_q, sport_d;
    logic [15:0] dport_q, dport_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [63:0] shreg_q, shreg_d;
    logic [6:0]  beat_q, beat_d;
    logic        err_q, err_d;

    logic        acc_clr;
    logic        acc_add;
    logic [15:0] sum_word;
    logic [15:0] csum;

    ones_comp_acc u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .add  (acc_add),
        .word (sum_word),
        .csum (csum)
    );

    always_comb begin
        case (wcnt_q)
            4'd0:    sum_word = src_ip_q[31:16];
            4'd1:    sum_word = src_ip_q[15:0];
            4'd2:    sum_word = dst_ip_q[31:16];
            4'd3:    sum_word = dst_ip_q[15:0];
            4'd4:    sum_word = {8'h00, PROTO_UDP};
            4'd5:    sum_word = len_q;
            4'd6:    sum_word = sport_q;
            4'd7:    sum_word = dport_q;
            4'd8:    sum_word = len_q;
            4'd9:    sum_word = dcs_q;
            default: sum_word = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        src_ip_d = src_ip_q;
        dst_ip_d = dst_ip_q;
        len_d    = len_q;
        dcs_d    = dcs_q;
        sport_d  = sport_q;
        dport_d  = dport_q;
        wcnt_d   = wcnt_q;
        shreg_d  = shreg_q;
        beat_d   = beat_q;
        err_d    = 1'b0;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.axiiv) begin
                    if (bus.protocol_in == PROTO_UDP) begin
                        src_ip_d = bus.src_ip_in;
                        dst_ip_d = bus.dst_ip_in;
                        len_d    = bus.data_length_in + 16'd8;
                        dcs_d    = bus.data_checksum_in;
                        sport_d  = bus.udp_src_port_in;
                        dport_d  = bus.udp_dst_port_in;
                        wcnt_d   = '0;
                        beat_d   = '0;
                        acc_clr  = 1'b1;
                        if (CHECKSUM_EN) begin
                            state_d = ST_SUM;
                        end else begin
                            shreg_d = {bus.udp_src_port_in, bus.udp_dst_port_in,
                                       bus.data_length_in + 16'd8, 16'h0000};
                            state_d = ST_SEND;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SUM: begin
                acc_add = 1'b1;
                wcnt_d  = wcnt_q + 4'd1;
                if (wcnt_q == 4'(SUM_WORDS - 1)) begin
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                // An all-zero checksum means "no checksum" in UDP, so send 0xFFFF.
                shreg_d = {sport_q, dport_q, len_q, (csum == 16'h0000) ? 16'hFFFF : csum};
                beat_d  = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.axiir) begin
                    shreg_d = shreg_q << N;
                    beat_d  = beat_q + 7'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            src_ip_q <= '0;
            dst_ip_q <= '0;
            len_q    <= '0;
            dcs_q    <= '0;
            sport_q  <= '0;
            dport_q  <= '0;
            wcnt_q   <= '0;
            shreg_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_ip_q <= src_ip_d;
            dst_ip_q <= dst_ip_d;
            len_q    <= len_d;
            dcs_q    <= dcs_d;
            sport_q  <= sport_d;
            dport_q  <= dport_d;
            wcnt_q   <= wcnt_d;
            shreg_q  <= shreg_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

    assign bus.axiov    = (state_q == ST_SEND);
    assign bus.axiod    = shreg_q[63 -: N];
    assign bus.axi_last = (state_q == ST_SEND) && (beat_q == LAST_BEAT);
    assign busy         = (state_q != ST_IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_transport_hdr_tx.sv
// Directed self-checking bench for transport_hdr_tx (N=2 with checksum, plus N=1/4/8 without).
module tb_transport_hdr_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] HDR_A  = 64'h04D2_162E_000C_6167;
    localparam logic [63:0] HDR_Z  = 64'h04D2_162E_000C_FFFF;
    localparam logic [63:0] HDR_NC = 64'h04D2_162E_000C_0000;

    transport_hdr_tx_if #(.N(2)) bus2 ();
    transport_hdr_tx_if #(.N(1)) bus1 ();
    transport_hdr_tx_if #(.N(4)) bus4 ();
    transport_hdr_tx_if #(.N(8)) bus8 ();
    logic busy2, err2, busy1, err1, busy4, err4, busy8, err8;

    transport_hdr_tx #(.N(2), .CHECKSUM_EN(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bus2), .busy(busy2), .err(err2));
    transport_hdr_tx #(.N(1), .CHECKSUM_EN(1'b0)) u_n1  (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .err(err1));
    transport_hdr_tx #(.N(4), .CHECKSUM_EN(1'b0)) u_n4  (.clk(clk), .rst(rst), .bus(bus4), .busy(busy4), .err(err4));
    transport_hdr_tx #(.N(8), .CHECKSUM_EN(1'b0)) u_n8  (.clk(clk), .rst(rst), .bus(bus8), .busy(busy8), .err(err8));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start2(input logic [7:0] proto, input logic [15:0] dcs);
        bus2.protocol_in      = proto;
        bus2.src_ip_in        = 32'hC0A8_010A;
        bus2.dst_ip_in        = 32'hC0A8_0114;
        bus2.data_length_in   = 16'd4;
        bus2.udp_src_port_in  = 16'd1234;
        bus2.udp_dst_port_in  = 16'd5678;
        bus2.data_checksum_in = dcs;
        bus2.axiiv            = 1'b1;
        tick();
        bus2.axiiv            = 1'b0;
    endtask

    // Collects beats from the N=2 instance; cycle numbers count edges since the start edge.
    task automatic capture2(input bit rnd, input int stop_after, input int cyc0,
                            output logic [63:0] hdr, output int beats, output int first,
                            output int lastbad, output int stallbad);
        int cyc;
        logic rdy, stalled, h_l;
        logic [1:0] h_d;
        hdr = '0; beats = 0; first = -1; lastbad = 0; stallbad = 0; cyc = cyc0;
        while (beats < stop_after && cyc < 400) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus2.axiir = rdy;
            stalled = 1'b0;
            h_d = '0; h_l = 1'b0;
            if (bus2.axiov === 1'b1) begin
                if (first < 0) first = cyc;
                if (rdy) begin
                    hdr = {hdr[61:0], bus2.axiod};
                    beats++;
                    if (bus2.axi_last !== (beats == 32)) lastbad++;
                end else begin
                    stalled = 1'b1;
                    h_d = bus2.axiod;
                    h_l = bus2.axi_last;
                end
            end else if (bus2.axi_last !== 1'b0) begin
                lastbad++;
            end
            tick();
            cyc++;
            if (stalled && (bus2.axiov !== 1'b1 || bus2.axiod !== h_d || bus2.axi_last !== h_l))
                stallbad++;
        end
        bus2.axiir = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy2); end
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err2); end
        total++; if (bus2.axiov !== 1'b0) begin bad++; $display("FAIL reset_axiov got=%b want=0", bus2.axiov); end
        total++; if (bus2.axiod !== 2'b00) begin bad++; $display("FAIL reset_axiod got=%h want=0", bus2.axiod); end
        total++; if (bus2.axi_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus2.axi_last); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_checksum;
        logic [63:0] hdr; int beats, first, lb, sb;
        start2(8'd17, 16'h0000);
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL cks_busy_rise got=%b want=1", busy2); end
        capture2(1'b0, 32, 1, hdr, beats, first, lb, sb);
        total++; if (hdr !== HDR_A) begin bad++; $display("FAIL cks_hdr got=%h want=%h", hdr, HDR_A); end
        total++; if (beats !== 32) begin bad++; $display("FAIL cks_beats got=%0d want=32", beats); end
        total++; if (first !== 12) begin bad++; $display("FAIL cks_first got=%0d want=12", first); end
        total++; if (lb !== 0) begin bad++; $display("FAIL cks_last got=%0d want=0", lb); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL cks_busy_fall got=%b want=0", busy2); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] hdr; int beats, first, lb, sb;
        start2(8'd17, 16'h0000);
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy2); end
        capture2(1'b0, 32, 1, hdr, beats, first, lb, sb);
        total++; if (hdr !== HDR_A) begin bad++; $display("FAIL b2b_hdr got=%h want=%h", hdr, HDR_A); end
        total++; if (first !== 12) begin bad++; $display("FAIL b2b_first got=%0d want=12", first); end
    endtask

    task automatic test_zero_subst;
        logic [63:0] hdr; int beats, first, lb, sb;
        start2(8'd17, 16'h6167);
        capture2(1'b0, 32, 1, hdr, beats, first, lb, sb);
        total++; if (hdr !== HDR_Z) begin bad++; $display("FAIL zero_hdr got=%h want=%h", hdr, HDR_Z); end
    endtask

    task automatic test_backpressure;
        logic [63:0] hdr; int beats, first, lb, sb;
        start2(8'd17, 16'h0000);
        capture2(1'b1, 32, 1, hdr, beats, first, lb, sb);
        total++; if (hdr !== HDR_A) begin bad++; $display("FAIL bp_hdr got=%h want=%h", hdr, HDR_A); end
        total++; if (beats !== 32) begin bad++; $display("FAIL bp_beats got=%0d want=32", beats); end
        total++; if (sb !== 0) begin bad++; $display("FAIL bp_stall got=%0d want=0", sb); end
        total++; if (lb !== 0) begin bad++; $display("FAIL bp_last got=%0d want=0", lb); end
    endtask

    task automatic test_busy_ignore;
        logic [63:0] hdr; int beats, first, lb, sb;
        start2(8'd17, 16'h0000);
        start2(8'd17, 16'h1234);
        start2(8'd6, 16'h0000);
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL busy_ign_err got=%b want=0", err2); end
        capture2(1'b0, 32, 3, hdr, beats, first, lb, sb);
        total++; if (hdr !== HDR_A) begin bad++; $display("FAIL busy_ign_hdr got=%h want=%h", hdr, HDR_A); end
        total++; if (first !== 12) begin bad++; $display("FAIL busy_ign_first got=%0d want=12", first); end
    endtask

    task automatic test_reject;
        int seen;
        start2(8'd6, 16'h0000);
        total++; if (err2 !== 1'b1) begin bad++; $display("FAIL rej_err got=%b want=1", err2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rej_busy got=%b want=0", busy2); end
        tick();
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL rej_err_pulse got=%b want=0", err2); end
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus2.axiov !== 1'b0 || busy2 !== 1'b0) seen++;
            tick();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rej_quiet got=%0d want=0", seen); end
        rst = 1'b1;
        start2(8'd17, 16'h0000);
        rst = 1'b0;
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rst_wins got=%b want=0", busy2); end
        tick();
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rst_wins2 got=%b want=0", busy2); end
    endtask

    task automatic test_reset_mid_send;
        logic [63:0] hdr; int beats, first, lb, sb;
        start2(8'd17, 16'h0000);
        capture2(1'b0, 10, 1, hdr, beats, first, lb, sb);
        total++; if (beats !== 10) begin bad++; $display("FAIL rms_reach got=%0d want=10", beats); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus2.axiov !== 1'b0) begin bad++; $display("FAIL rms_axiov got=%b want=0", bus2.axiov); end
        total++; if (bus2.axi_last !== 1'b0) begin bad++; $display("FAIL rms_last got=%b want=0", bus2.axi_last); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rms_busy got=%b want=0", busy2); end
        total++; if (bus2.axiod !== 2'b00) begin bad++; $display("FAIL rms_axiod got=%h want=0", bus2.axiod); end
        start2(8'd17, 16'h0000);
        capture2(1'b0, 32, 1, hdr, beats, first, lb, sb);
        total++; if (hdr !== HDR_A) begin bad++; $display("FAIL rms_hdr got=%h want=%h", hdr, HDR_A); end
        total++; if (beats !== 32) begin bad++; $display("FAIL rms_beats got=%0d want=32", beats); end
    endtask

    task automatic test_sweep;
        logic [63:0] h1, h4, h8;
        int b1, b4, b8, f1, f4, f8, lb;
        h1 = '0; h4 = '0; h8 = '0; b1 = 0; b4 = 0; b8 = 0; f1 = -1; f4 = -1; f8 = -1; lb = 0;
        bus1.protocol_in = 8'd17; bus1.data_length_in = 16'd4; bus1.udp_src_port_in = 16'd1234; bus1.udp_dst_port_in = 16'd5678;
        bus4.protocol_in = 8'd17; bus4.data_length_in = 16'd4; bus4.udp_src_port_in = 16'd1234; bus4.udp_dst_port_in = 16'd5678;
        bus8.protocol_in = 8'd17; bus8.data_length_in = 16'd4; bus8.udp_src_port_in = 16'd1234; bus8.udp_dst_port_in = 16'd5678;
        bus1.axiir = 1'b1; bus4.axiir = 1'b1; bus8.axiir = 1'b1;
        bus1.axiiv = 1'b1; bus4.axiiv = 1'b1; bus8.axiiv = 1'b1;
        tick();
        bus1.axiiv = 1'b0; bus4.axiiv = 1'b0; bus8.axiiv = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (bus1.axiov === 1'b1) begin
                if (f1 < 0) f1 = cyc;
                h1 = {h1[62:0], bus1.axiod}; b1++;
                if (bus1.axi_last !== (b1 == 64)) lb++;
            end
            if (bus4.axiov === 1'b1) begin
                if (f4 < 0) f4 = cyc;
                h4 = {h4[59:0], bus4.axiod}; b4++;
                if (bus4.axi_last !== (b4 == 16)) lb++;
            end
            if (bus8.axiov === 1'b1) begin
                if (f8 < 0) f8 = cyc;
                h8 = {h8[55:0], bus8.axiod}; b8++;
                if (bus8.axi_last !== (b8 == 8)) lb++;
            end
            tick();
        end
        total++; if (h1 !== HDR_NC) begin bad++; $display("FAIL n1_hdr got=%h want=%h", h1, HDR_NC); end
        total++; if (h4 !== HDR_NC) begin bad++; $display("FAIL n4_hdr got=%h want=%h", h4, HDR_NC); end
        total++; if (h8 !== HDR_NC) begin bad++; $display("FAIL n8_hdr got=%h want=%h", h8, HDR_NC); end
        total++; if (b1 !== 64) begin bad++; $display("FAIL n1_beats got=%0d want=64", b1); end
        total++; if (b4 !== 16) begin bad++; $display("FAIL n4_beats got=%0d want=16", b4); end
        total++; if (b8 !== 8) begin bad++; $display("FAIL n8_beats got=%0d want=8", b8); end
        total++; if (f1 !== 1) begin bad++; $display("FAIL n1_first got=%0d want=1", f1); end
        total++; if (f4 !== 1) begin bad++; $display("FAIL n4_first got=%0d want=1", f4); end
        total++; if (f8 !== 1) begin bad++; $display("FAIL n8_first got=%0d want=1", f8); end
        total++; if (lb !== 0) begin bad++; $display("FAIL sweep_last got=%0d want=0", lb); end
    endtask

    initial begin
        rst = 1'b1;
        bus2.axiiv = 1'b0; bus2.axiir = 1'b1; bus2.protocol_in = '0; bus2.src_ip_in = '0; bus2.dst_ip_in = '0;
        bus2.data_length_in = '0; bus2.data_checksum_in = '0; bus2.udp_src_port_in = '0; bus2.udp_dst_port_in = '0;
        bus1.axiiv = 1'b0; bus1.axiir = 1'b0; bus1.protocol_in = '0; bus1.src_ip_in = '0; bus1.dst_ip_in = '0;
        bus1.data_length_in = '0; bus1.data_checksum_in = '0; bus1.udp_src_port_in = '0; bus1.udp_dst_port_in = '0;
        bus4.axiiv = 1'b0; bus4.axiir = 1'b0; bus4.protocol_in = '0; bus4.src_ip_in = '0; bus4.dst_ip_in = '0;
        bus4.data_length_in = '0; bus4.data_checksum_in = '0; bus4.udp_src_port_in = '0; bus4.udp_dst_port_in = '0;
        bus8.axiiv = 1'b0; bus8.axiir = 1'b0; bus8.protocol_in = '0; bus8.src_ip_in = '0; bus8.dst_ip_in = '0;
        bus8.data_length_in = '0; bus8.data_checksum_in = '0; bus8.udp_src_port_in = '0; bus8.udp_dst_port_in = '0;
        test_reset();
        test_checksum();
        test_back_to_back();
        test_zero_subst();
        test_backpressure();
        test_busy_ignore();
        test_reject();
        test_reset_mid_send();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/transport_hdr_tx.md
# transport_hdr_tx

Parametrised transport-layer header generator for the FPGA network TX path. It sits between the IP TX stage and the MAC/PHY serializer. On a start pulse it latches the IP pseudo-header fields and the UDP port fields, then computes the UDP checksum internally over several cycles. It then streams the 8-byte UDP header MSB-first in N-bit beats with downstream backpressure. Unsupported protocols are rejected with an error pulse instead of being silently zeroed.

## Interface
- N, default 2: stream beat width in bits; legal values 1, 2, 4, 8.
- CHECKSUM_EN, default 1: 1 computes the UDP checksum; 0 transmits checksum field 0x0000 and skips the SUM/FOLD states.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- axiiv  in  1  start strobe; fields sampled on this cycle when idle.
- protocol_in  in  8  IP protocol number; only 17 (UDP) is accepted.
- src_ip_in  in  32  IPv4 source address.
- dst_ip_in  in  32  IPv4 destination address.
- data_length_in  in  16  UDP payload length in bytes, header excluded.
- data_checksum_in  in  16  uncomplemented 16-bit one's-complement sum of payload; odd payloads are zero-padded.
- udp_src_port_in  in  16  UDP source port.
- udp_dst_port_in  in  16  UDP destination port.
- axiir  in  1  downstream ready.
- axiov  out  1  header beat valid.
- axiod  out  N  header beat data, MSB-first.
- axi_last  out  1  final header beat.
- busy  out  1  high whenever the block is not in IDLE.
- err  out  1  one-cycle pulse: start rejected because of protocol.

## Operation
- States: IDLE, SUM, FOLD, SEND.
- IDLE, axiiv=1, protocol_in=17: latch all fields; udp_len = data_length_in + 8, mod 2^16, no saturation. Go to SUM, or to SEND when CHECKSUM_EN=0.
- IDLE, axiiv=1, protocol_in≠17: err=1 for that cycle only; stay IDLE; nothing latched.
- axiiv while busy: ignored, no err.
- SUM: 10 cycles, one 16-bit word added per cycle into a 20-bit accumulator, in this order:
  - src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0]
  - 0x0011, udp_len, src_port, dst_port, udp_len, data_checksum
- FOLD: 1 cycle. Fold carries twice (acc[15:0]+acc[19:16], repeated), then complement. A result of 0x0000 is sent as 0xFFFF.
- SEND: 64-bit header {src_port, dst_port, udp_len, csum} in a shift register, emitted as 64/N beats MSB-first.
  - A beat completes when axiov && axiir; the register shifts by N on completion.
  - axi_last is asserted together with axiov on the final beat only.
  - After the final beat completes, return to IDLE.

## Timing
- Reset values: axiov=0, axiod=0, axi_last=0, busy=0, err=0, state=IDLE, accumulator=0.
- Start sampled at cycle 0:
  - CHECKSUM_EN=1: SUM occupies cycles 1–10, FOLD cycle 11, first axiov at cycle 12.
  - CHECKSUM_EN=0: first axiov at cycle 1.
- With axiir held high, beats occur on consecutive cycles. IDLE is re-entered the cycle after the last beat, so the next start is accepted 1 cycle after axi_last completes.
- Backpressure: while axiov && !axiir, axiod, axi_last and axiov hold stable. axiov never drops without a completed beat.
- busy rises the cycle after an accepted start and falls on the IDLE re-entry cycle.
- err is registered: it goes high the cycle after the rejected strobe.
- rst at any point, including mid-SUM or mid-SEND: all outputs return to reset values next cycle; the partial header is abandoned with no axi_last.
- rst and axiiv in the same cycle: rst wins; the start is dropped.

## Structure
- Shared package net_pkg holds:
  - protocol constants: PROTO_UDP=8'd17, later PROTO_TCP=8'd6
  - UDP_HDR_BYTES=8
  - state enum typedef
  - one's-complement add/fold function, shared with the IP checksum block
- One sub-module is natural: ones_comp_acc, a 16-bit word accumulator with clear, add and fold/complement outputs, reused by the IP header TX.

## Test plan
- Checksum vector, N=2, axiir=1:
  - Stimulus: src 192.168.1.10, dst 192.168.1.20, data_length 4, ports 1234→5678, data_checksum 0x0000.
  - Required header: 0x04D2 162E 000C 6167; 32 beats; axi_last on beat 32; first axiov at cycle 12.
- Zero-result substitution: choose data_checksum so the complement is 0x0000 → checksum field transmitted as 0xFFFF.
- Backpressure: same vector as the first scenario, axiir random ~50% → identical 32-beat sequence; axiod stable during every stall.
- Protocol reject: protocol_in=6 with axiiv → one err pulse; busy stays 0; no axiov.
- Reset mid-SEND: rst at beat 10 → axiov=0 next cycle. A new start then produces a complete, correct header.
- Parameter sweep: N∈{1,4,8} and CHECKSUM_EN=0 → 64/N beats; checksum field 0x0000; first beat at cycle 1.
